// File: rtl/tagdv_walker_pkg.sv
// Shared types for the TagDV maintenance walker: entry layout, sweep opcodes, FSM states.
package tagdv_walker_pkg;

   localparam int unsigned TAGDV_RAM_WIDTH = 22;
   localparam int unsigned TAGDV_RAM_DEPTH = 256;

   // One TagDV entry; all-zeros means an invalid, clean line with no tag.
   typedef struct packed {
      logic [TAGDV_RAM_WIDTH-3:0] tag;
      logic                       dirty;
      logic                       valid;
   } tagdv_entry_t;

   typedef enum logic {
      OP_INV   = 1'b0,
      OP_WBINV = 1'b1
   } walker_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StRd,
      StChk,
      StWb,
      StFin
   } walker_state_e;

   // Low two entry bits are {dirty, valid}; only dirty valid lines need a writeback.
   function automatic logic needs_wb(input logic [1:0] dv);
      return dv == 2'b11;
   endfunction

endpackage

// File: rtl/tagdv_walker.sv
// TagDV sweep engine: invalidate-all and writeback-invalidate-all over one cache way.
// Optional feature macro: TAGDV_AUTO_INIT_EN (reset starts an invalidate-all sweep).
module tagdv_walker
   import tagdv_walker_pkg::*;
#(
   parameter int unsigned RAM_WIDTH = TAGDV_RAM_WIDTH,
   parameter int unsigned RAM_DEPTH = TAGDV_RAM_DEPTH,
   localparam int unsigned IDX_W    = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   input  logic                 cmd_op,
   output logic                 cmd_ready,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_W-1:0]     ram_addrb,
   input  logic [RAM_WIDTH-1:0] ram_doutb,
   output logic [IDX_W-1:0]     ram_addra,
   output logic [RAM_WIDTH-1:0] ram_dina,
   output logic                 ram_wea,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [IDX_W-1:0]     wb_index,
   output logic [RAM_WIDTH-3:0] wb_tag
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RAM_DEPTH - 1);

`ifdef TAGDV_AUTO_INIT_EN
   localparam walker_state_e ResetState = StClr;
`else
   localparam walker_state_e ResetState = StIdle;
`endif

   walker_state_e          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [RAM_WIDTH-3:0]   tag_q, tag_d;

   // Next-state and per-state strobes; the index stops at the last entry instead of wrapping.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tag_d    = tag_q;
      ram_wea  = 1'b0;
      wb_valid = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               idx_d   = '0;
               state_d = (walker_op_e'(cmd_op) == OP_WBINV) ? StRd : StClr;
            end
         end
         StClr: begin
            ram_wea = 1'b1;
            if (idx_q == LastIdx) begin
               state_d = StFin;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StRd: begin
            state_d = StChk;
         end
         StChk: begin
            if (needs_wb(ram_doutb[1:0])) begin
               tag_d   = ram_doutb[RAM_WIDTH-1:2];
               state_d = StWb;
            end else begin
               ram_wea = 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = StFin;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRd;
               end
            end
         end
         StWb: begin
            wb_valid = 1'b1;
            // The line is cleared on the handshake cycle, so the tag is never lost.
            if (wb_ready) begin
               ram_wea = 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = StFin;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRd;
               end
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, index and latched writeback tag; reset aborts any sweep in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ResetState;
         idx_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
      end
   end

   // Both RAM ports and the writeback index all follow the sweep index.
   always_comb begin
      cmd_ready = (state_q == StIdle);
      busy      = (state_q != StIdle);
      ram_addrb = idx_q;
      ram_addra = idx_q;
      ram_dina  = '0;
      wb_index  = idx_q;
      wb_tag    = tag_q;
   end

endmodule

// File: tb/tb_tagdv_walker.sv
// Self-checking bench for tagdv_walker: behavioural TagDV RAM, event monitor, reference model.
module tb_tagdv_walker;
   import tagdv_walker_pkg::*;

   localparam int W  = 22;
   localparam int D  = 256;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_op = 1'b0;
   logic          wb_ready = 1'b1;
   logic          cmd_ready, busy, done, ram_wea, wb_valid;
   logic [IW-1:0] ram_addrb, ram_addra, wb_index;
   logic [W-1:0]  ram_doutb, ram_dina;
   logic [W-3:0]  wb_tag;

   logic [W-1:0]  mem [D];
   logic [W-1:0]  img [D];
   logic          load = 1'b0;

   typedef struct {
      int c;
      int a;
      int t;
   } ev_t;

   ev_t wr_q[$];
   ev_t wb_q[$];
   ev_t exp_q[$];
   int  done_q[$];
   int  cyc = 0;
   int  stab_viol = 0, hs_viol = 0, din_viol = 0, wbv_cnt = 0;
   logic          pv = 1'b0, phs = 1'b0;
   logic [IW-1:0] pidx = '0;
   logic [W-3:0]  ptag = '0;
   int  total = 0, bad = 0;

   tagdv_walker dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .busy      (busy),
      .done      (done),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_wea   (ram_wea),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_index  (wb_index),
      .wb_tag    (wb_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Simple dual-port RAM with registered read; 'load' copies the whole image in one cycle.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < D; i++) mem[i] <= img[i];
      end else if (ram_wea) begin
         mem[ram_addra] <= ram_dina;
      end
      ram_doutb <= mem[ram_addrb];
   end

   // Event log and protocol watchers, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_wea) wr_q.push_back('{cyc, int'(ram_addra), 0});
         if (wb_valid && wb_ready) wb_q.push_back('{cyc, int'(wb_index), int'(wb_tag)});
         if (done) done_q.push_back(cyc);
         if (pv && !phs && (wb_valid !== 1'b1 || wb_index !== pidx || wb_tag !== ptag))
            stab_viol <= stab_viol + 1;
         if (wb_valid && wb_ready && !(ram_wea && ram_addra == wb_index)) hs_viol <= hs_viol + 1;
         if (ram_wea && ram_dina != '0) din_viol <= din_viol + 1;
         if (wb_valid) wbv_cnt <= wbv_cnt + 1;
      end
      pv   <= wb_valid && !rst;
      phs  <= wb_valid && wb_ready;
      pidx <= wb_index;
      ptag <= wb_tag;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_img();
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Random image; roughly a quarter of the lines come out dirty and valid.
   task automatic rand_img(input bit force_valid);
      logic [31:0] r;
      for (int i = 0; i < D; i++) begin
         r = $urandom;
         img[i] = r[W-1:0];
         if (force_valid) img[i][0] = 1'b1;
      end
   endtask

   // Reference: writeback requests are the dirty valid lines in ascending index order.
   task automatic build_exp();
      exp_q.delete();
      for (int i = 0; i < D; i++)
         if (img[i][1] && img[i][0]) exp_q.push_back('{0, i, int'(img[i][W-1:2])});
   endtask

   // Issues a command at this cycle; returns the cycle number of the accepting edge minus one.
   task automatic start(input logic op, output int a);
      cmd_valid = 1'b1;
      cmd_op    = op;
      a         = cyc;
      step();
      cmd_valid = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
   endtask

   // mode 0: ready always; 1: random ready; 2: ready low for the first 10 WB cycles.
   task automatic run_sweep(input int mode, input int bound);
      int bp = 0;
      int d0 = done_q.size();
      int n  = 0;
      while (done_q.size() == d0 && n < bound) begin
         case (mode)
            1:       wb_ready = ($urandom % 3) != 0;
            2: begin
               if (wb_valid && bp < 10) begin
                  wb_ready = 1'b0;
                  bp++;
               end else begin
                  wb_ready = 1'b1;
               end
            end
            default: wb_ready = 1'b1;
         endcase
         step();
         n++;
      end
      wb_ready = 1'b1;
      chk("done_in_bound", 32'(done_q.size() > d0), 32'd1);
   endtask

   task automatic check_writes(input string nm, input int w0, input int a, input bit exact);
      int nbad = 0;
      int nz   = 0;
      chk({nm, "_nwr"}, 32'(wr_q.size() - w0), 32'(D));
      for (int j = 0; j < D && w0 + j < wr_q.size(); j++) begin
         if (wr_q[w0+j].a != j) nbad++;
         if (exact && wr_q[w0+j].c != a + 1 + j) nbad++;
      end
      chk({nm, "_wrseq"}, 32'(nbad), 32'd0);
      for (int i = 0; i < D; i++) if (mem[i] !== '0) nz++;
      chk({nm, "_allzero"}, 32'(nz), 32'd0);
   endtask

   task automatic check_wb(input string nm, input int b0);
      int mism = 0;
      chk({nm, "_nreq"}, 32'(wb_q.size() - b0), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && b0 + j < wb_q.size(); j++)
         if (wb_q[b0+j].a != exp_q[j].a || wb_q[b0+j].t != exp_q[j].t) mism++;
      chk({nm, "_reqs"}, 32'(mism), 32'd0);
   endtask

   task automatic check_one_done(input string nm, input int d0);
      repeat (4) step();
      chk({nm, "_ndone"}, 32'(done_q.size() - d0), 32'd1);
      chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int a, w0, b0, d0, v0, found;
      tagdv_entry_t e;

      // Reset values
      rst = 1'b1;
      repeat (3) step();
`ifdef TAGDV_AUTO_INIT_EN
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
`else
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wea", 32'(ram_wea), 32'd0);
`endif
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_addra", 32'(ram_addra), 32'd0);
      chk("rst_addrb", 32'(ram_addrb), 32'd0);
      chk("rst_wb_index", 32'(wb_index), 32'd0);
      chk("rst_wb_tag", 32'(wb_tag), 32'd0);

      for (int i = 0; i < D; i++) img[i] = '1;
      load_img();
`ifdef TAGDV_AUTO_INIT_EN
      w0 = wr_q.size();
      d0 = done_q.size();
      rst = 1'b0;
      run_sweep(0, 1000);
      check_writes("autoinit", w0, 0, 1'b0);
      check_one_done("autoinit", d0);
`else
      rst = 1'b0;
      step();
`endif

      // Invalidate-all over an all-ones RAM, exact timing
      for (int i = 0; i < D; i++) img[i] = '1;
      load_img();
      w0 = wr_q.size(); b0 = wb_q.size(); d0 = done_q.size();
      start(1'b0, a);
      run_sweep(0, 1000);
      check_writes("inv", w0, a, 1'b1);
      chk("inv_done_cyc", 32'(done_q[d0]), 32'(a + D + 1));
      chk("inv_no_wb", 32'(wb_q.size() - b0), 32'd0);
      check_one_done("inv", d0);

      // Directed writeback sweep: one dirty line, one clean valid line
      for (int i = 0; i < D; i++) img[i] = '0;
      e = '{tag: 20'h12345, dirty: 1'b1, valid: 1'b1};
      img[3] = e;
      e = '{tag: 20'hABCDE, dirty: 1'b0, valid: 1'b1};
      img[200] = e;
      load_img();
      build_exp();
      w0 = wr_q.size(); b0 = wb_q.size(); d0 = done_q.size();
      start(1'b1, a);
      run_sweep(0, 2000);
      check_writes("wbdir", w0, a, 1'b0);
      check_wb("wbdir", b0);
      chk("wbdir_done_cyc", 32'(done_q[d0]), 32'(a + 2 * D + 2));
      check_one_done("wbdir", d0);

      // Backpressure on the last line
      for (int i = 0; i < D; i++) img[i] = '0;
      e = '{tag: 20'(($urandom % 20'hFFFFF) + 1), dirty: 1'b1, valid: 1'b1};
      img[D-1] = e;
      load_img();
      build_exp();
      w0 = wr_q.size(); b0 = wb_q.size(); d0 = done_q.size(); v0 = wbv_cnt;
      start(1'b1, a);
      run_sweep(2, 2000);
      check_writes("bp", w0, a, 1'b0);
      check_wb("bp", b0);
      chk("bp_wbv_cycles", 32'(wbv_cnt - v0), 32'd11);
      if (wb_q.size() > b0 && wr_q.size() > w0) begin
         chk("bp_clear_on_hs", 32'(wr_q[wr_q.size()-1].c), 32'(wb_q[b0].c));
         chk("bp_done_after_hs", 32'(done_q[d0]), 32'(wb_q[b0].c + 1));
      end
      chk("bp_done_cyc", 32'(done_q[d0]), 32'(a + 2 * D + 12));
      check_one_done("bp", d0);

      // Random images with random writeback backpressure
      for (int r = 0; r < 3; r++) begin
         rand_img(1'b0);
         load_img();
         build_exp();
         w0 = wr_q.size(); b0 = wb_q.size(); d0 = done_q.size();
         start(1'b1, a);
         run_sweep(1, 5000);
         check_writes("rnd", w0, a, 1'b0);
         check_wb("rnd", b0);
         chk("rnd_done_after_last_wr", 32'(done_q[d0]), 32'(wr_q[wr_q.size()-1].c + 1));
         check_one_done("rnd", d0);
      end

      // Commands while busy are dropped
      rand_img(1'b0);
      load_img();
      w0 = wr_q.size(); b0 = wb_q.size(); d0 = done_q.size();
      start(1'b0, a);
      repeat (49) step();
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      repeat (3) step();
      cmd_valid = 1'b0;
      run_sweep(0, 1000);
      check_writes("busyrej", w0, a, 1'b1);
      chk("busyrej_done_cyc", 32'(done_q[d0]), 32'(a + D + 1));
      chk("busyrej_no_wb", 32'(wb_q.size() - b0), 32'd0);
      check_one_done("busyrej", d0);

      // Reset in the middle of a writeback sweep
      rand_img(1'b1);
      load_img();
      d0 = done_q.size();
      start(1'b1, a);
      found = 0;
      for (int n = 0; n < 2000 && found == 0; n++) begin
         if (busy && ram_addrb == 8'd100) found = 1;
         else step();
      end
      chk("midrst_reach_idx100", 32'(found), 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
`ifndef TAGDV_AUTO_INIT_EN
      chk("midrst_wea", 32'(ram_wea), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
`endif
      rst = 1'b0;
      repeat (5) step();
`ifdef TAGDV_AUTO_INIT_EN
      run_sweep(0, 1000);
`else
      chk("midrst_no_done", 32'(done_q.size() - d0), 32'd0);
      begin
         int nt = 0;
         int nc = 0;
         for (int i = 0; i < 100; i++) if (mem[i] !== '0) nc++;
         for (int i = 100; i < D; i++) if (mem[i] !== img[i]) nt++;
         chk("midrst_low_cleared", 32'(nc), 32'd0);
         chk("midrst_high_untouched", 32'(nt), 32'd0);
      end
`endif

      // Protocol watchers over the whole run
      chk("wb_stability", 32'(stab_viol), 32'd0);
      chk("clear_on_handshake", 32'(hs_viol), 32'd0);
      chk("write_data_zero", 32'(din_viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
